// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel button debouncer.
// Latency: n/a (types and constant functions only).
// Backpressure: none.
//   db_state_e  - per-channel debounce FSM states
//   cnt_width() - width large enough to hold any of the three counts without wrap
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single-channel debouncer: 2-flop synchroniser, press/release FSM, hold/auto-repeat counter.
// Latency: press/release pulse N_DB+3 edges after a clean raw edge; hold N_HOLD cycles after press.
// Backpressure: none; pulses are one-cycle and never stalled.
//   clk_i      - clock            rst_i     - synchronous active-high reset
//   ent_i      - raw button input level_o   - debounced state (PRESSED or RELEASE_WAIT)
//   press_o    - accepted press   release_o - accepted release   hold_o - long-press/repeat pulse
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int N_DB       = 8000,
  parameter int N_HOLD     = 500000,
  parameter int N_REPEAT   = 100000,
  parameter int REPEAT_EN  = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ent_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam int            CW        = cnt_width(N_DB, N_HOLD, N_REPEAT);
  localparam logic [CW-1:0] DB_LAST   = CW'(N_DB - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(N_HOLD - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(N_REPEAT - 1);
  localparam logic          INACTIVE  = (ACTIVE_LOW != 0);
  localparam logic          ONE_SHOT  = (REPEAT_EN == 0);

  logic          sync1_q, sync2_q;
  logic          active;
  db_state_e     state_q, state_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [CW-1:0] hold_last;
  logic          rep_q, rep_d;    // first hold pulse already emitted; now counting repeats
  logic          done_q, done_d;  // one-shot mode: no further hold pulses this press
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          hold_q, hold_d;

  assign active = sync2_q ^ INACTIVE;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= INACTIVE;
      sync2_q    <= INACTIVE;
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_q      <= 1'b0;
      done_q     <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      sync1_q    <= ent_i;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_q      <= rep_d;
      done_q     <= done_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rep_d      = rep_q;
    done_d     = done_q;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    hold_d     = 1'b0;
    // The hold counter restarts after every pulse, so it never exceeds the larger threshold.
    hold_last  = rep_q ? REP_LAST : HOLD_LAST;

    unique case (state_q)
      IDLE: begin
        db_cnt_d   = '0;
        hold_cnt_d = '0;
        rep_d      = 1'b0;
        done_d     = 1'b0;
        if (active) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!active) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = PRESSED;
          press_d    = 1'b1;
          hold_cnt_d = '0;
          rep_d      = 1'b0;
          done_d     = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        // This cycle counts toward hold even if the input just dropped.
        if (!done_q) begin
          if (hold_cnt_q == hold_last) begin
            hold_d     = 1'b1;
            hold_cnt_d = '0;
            rep_d      = 1'b1;
            done_d     = ONE_SHOT;
          end else begin
            hold_cnt_d = hold_cnt_q + CW'(1);
          end
        end
        if (!active) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        // Hold counter is frozen here; a bounce back keeps its progress.
        if (active) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level_o   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign hold_o    = hold_q;

endmodule

// File: rtl/debounce_multi.sv
// NCH independent button debouncers with press/release/hold pulse outputs.
// Latency: press/release N_DB+3 edges after a clean raw edge; hold N_HOLD cycles after press.
// Backpressure: none; every channel pulses independently, several may pulse in one cycle.
//   clk_i, rst_i - clock and synchronous active-high reset
//   ent_i        - raw asynchronous button inputs, one bit per channel
//   level_o      - debounced levels; press_o/release_o/hold_o - one-cycle event pulses
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int N_DB       = 8000,
  parameter int N_HOLD     = 500000,
  parameter int N_REPEAT   = 100000,
  parameter int REPEAT_EN  = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [NCH-1:0] ent_i,
  output logic [NCH-1:0] level_o,
  output logic [NCH-1:0] press_o,
  output logic [NCH-1:0] release_o,
  output logic [NCH-1:0] hold_o
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    debounce_ch #(
      .N_DB      (N_DB),
      .N_HOLD    (N_HOLD),
      .N_REPEAT  (N_REPEAT),
      .REPEAT_EN (REPEAT_EN),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .ent_i    (ent_i[g]),
      .level_o  (level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .hold_o   (hold_o[g])
    );
  end

endmodule
